// File: rtl/warp_arbiter.sv
// warp_arbiter: round-robin ownership of a shared fetch/decode/execute pipeline
// across resident warps. The owner keeps the pipeline until it retires (RET) or
// stays stalled long enough; the handoff then costs a one-cycle SWITCH bubble.
// Optional build macro WARP_ARBITER_STATS_EN adds a saturating switch_count.
module warp_arbiter #(
   parameter int unsigned NUM_WARPS       = 2,
   parameter int unsigned WARP_BITS       = $clog2(NUM_WARPS),
   parameter int unsigned STALL_THRESHOLD = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NUM_WARPS-1:0] warp_active,
   input  logic [NUM_WARPS-1:0] warp_ready,
   input  logic                 active_stalled,
   input  logic                 active_done,
   output logic [WARP_BITS-1:0] warp_select,
   output logic                 switch_pulse,
   output logic                 all_done,
   output logic [NUM_WARPS-1:0] done_mask
`ifdef WARP_ARBITER_STATS_EN
   ,
   output logic [15:0]          switch_count
`endif
);

   localparam int unsigned      CNT_W   = $clog2(STALL_THRESHOLD + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_THRESHOLD);
   localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STALL_THRESHOLD - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_SWITCH, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [WARP_BITS-1:0] sel_d;
   logic [WARP_BITS-1:0] next_q, next_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_WARPS-1:0] mask_d;
   logic [WARP_BITS:0]   done_pick;
   logic [WARP_BITS:0]   stall_pick;
`ifdef WARP_ARBITER_STATS_EN
   logic [15:0]          count_d;
`endif

   // First eligible warp after cur in round-robin order; MSB flags a hit.
   function automatic logic [WARP_BITS:0] rr_pick(input logic [NUM_WARPS-1:0] elig,
                                                  input logic [WARP_BITS-1:0] cur);
      logic [WARP_BITS:0] res;
      int unsigned        idx;
      res = '0;
      for (int unsigned k = NUM_WARPS - 1; k >= 1; k--) begin
         idx = (32'(cur) + k) % NUM_WARPS;
         if (elig[WARP_BITS'(idx)]) res = {1'b1, WARP_BITS'(idx)};
      end
      return res;
   endfunction

   // Index of the lowest set bit (0 when none).
   function automatic logic [WARP_BITS-1:0] lowest(input logic [NUM_WARPS-1:0] v);
      logic [WARP_BITS-1:0] r;
      r = '0;
      for (int unsigned k = NUM_WARPS; k > 0; k--) begin
         if (v[WARP_BITS'(k - 1)]) r = WARP_BITS'(k - 1);
      end
      return r;
   endfunction

   // Next-state, stall counter and completion bookkeeping.
   always_comb begin
      state_d    = state_q;
      sel_d      = warp_select;
      next_d     = next_q;
      cnt_d      = cnt_q;
      mask_d     = done_mask;
`ifdef WARP_ARBITER_STATS_EN
      count_d    = switch_count;
`endif
      done_pick  = rr_pick(warp_active & ~done_mask, warp_select);
      stall_pick = rr_pick(warp_active & warp_ready & ~done_mask, warp_select);

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start) begin
               if (|warp_active) begin
                  sel_d   = lowest(warp_active);
                  state_d = S_RUN;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (!active_stalled)     cnt_d = '0;
            else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            // Retirement outranks a coincident stall; ready is not needed to take over.
            if (active_done) begin
               mask_d[warp_select] = 1'b1;
               if (done_pick[WARP_BITS]) begin
                  next_d  = done_pick[WARP_BITS-1:0];
                  state_d = S_SWITCH;
               end else begin
                  state_d = S_DONE;
               end
            end else if (active_stalled && cnt_q >= CNT_HIT) begin
               // Saturated counter keeps re-checking until a ready warp appears.
               if (stall_pick[WARP_BITS]) begin
                  next_d  = stall_pick[WARP_BITS-1:0];
                  state_d = S_SWITCH;
               end
            end
         end
         S_SWITCH: begin
            sel_d   = next_q;
            cnt_d   = '0;
            state_d = S_RUN;
`ifdef WARP_ARBITER_STATS_EN
            if (switch_count != 16'hFFFF) count_d = switch_count + 16'd1;
`endif
         end
         S_DONE: begin
            cnt_d = '0;
            if (!start) begin
               mask_d  = '0;
               state_d = S_IDLE;
`ifdef WARP_ARBITER_STATS_EN
               count_d = '0;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         warp_select  <= '0;
         next_q       <= '0;
         cnt_q        <= '0;
         done_mask    <= '0;
         switch_pulse <= 1'b0;
         all_done     <= 1'b0;
`ifdef WARP_ARBITER_STATS_EN
         switch_count <= '0;
`endif
      end else begin
         state_q      <= state_d;
         warp_select  <= sel_d;
         next_q       <= next_d;
         cnt_q        <= cnt_d;
         done_mask    <= mask_d;
         switch_pulse <= (state_d == S_SWITCH);
         all_done     <= (state_d == S_DONE);
`ifdef WARP_ARBITER_STATS_EN
         switch_count <= count_d;
`endif
      end
   end

endmodule

// File: tb/tb_warp_arbiter.sv
// tb_warp_arbiter: directed 2-warp scenarios plus a randomized 4-warp run
// checked every cycle against a behavioural model of the arbitration rules.
module tb_warp_arbiter;

   localparam int TH = 2;
   localparam int N4 = 4;

   logic clk;
   int   checks = 0;
   int   errors = 0;

   // 2-warp instance
   logic       rst2, st2, stl2, dn2;
   logic [1:0] act2, rdy2, dm2;
   logic       sel2, sp2, ad2;
   // 4-warp instance
   logic       rst4, st4, stl4, dn4;
   logic [3:0] act4, rdy4, dm4;
   logic [1:0] sel4;
   logic       sp4, ad4;
`ifdef WARP_ARBITER_STATS_EN
   logic [15:0] sc2, sc4;
`endif

   warp_arbiter #(.NUM_WARPS(2), .STALL_THRESHOLD(TH)) dut2 (
      .clk(clk), .reset(rst2), .start(st2), .warp_active(act2), .warp_ready(rdy2),
      .active_stalled(stl2), .active_done(dn2), .warp_select(sel2),
      .switch_pulse(sp2), .all_done(ad2), .done_mask(dm2)
`ifdef WARP_ARBITER_STATS_EN
      , .switch_count(sc2)
`endif
   );

   warp_arbiter #(.NUM_WARPS(N4), .STALL_THRESHOLD(TH)) dut4 (
      .clk(clk), .reset(rst4), .start(st4), .warp_active(act4), .warp_ready(rdy4),
      .active_stalled(stl4), .active_done(dn4), .warp_select(sel4),
      .switch_pulse(sp4), .all_done(ad4), .done_mask(dm4)
`ifdef WARP_ARBITER_STATS_EN
      , .switch_count(sc4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the 4-warp instance: phase 0 waiting, 1 owned, 2 handoff, 3 finished.
   int       m_phase = 0;
   int       m_owner = 0;
   int       m_target = 0;
   int       m_run = 0;
   bit [3:0] m_fin = '0;
   int       m_sw = 0;

   function automatic int scan(input int from, input bit need_ready);
      for (int k = 1; k < N4; k++) begin
         int w;
         w = (from + k) % N4;
         if (act4[w] && !m_fin[w] && (!need_ready || rdy4[w])) return w;
      end
      return -1;
   endfunction

   function automatic void model_clock();
      int c;
      if (rst4) begin
         m_phase = 0; m_owner = 0; m_target = 0; m_run = 0; m_fin = '0; m_sw = 0;
         return;
      end
      case (m_phase)
         0: if (st4) begin
               if (act4 != 0) begin
                  for (int w = N4 - 1; w >= 0; w--) if (act4[w]) m_owner = w;
                  m_run   = 0;
                  m_phase = 1;
               end else begin
                  m_phase = 3;
               end
            end
         1: begin
               m_run = stl4 ? m_run + 1 : 0;
               if (dn4) begin
                  m_fin[m_owner] = 1'b1;
                  c = scan(m_owner, 1'b0);
                  if (c >= 0) begin m_target = c; m_phase = 2; end
                  else m_phase = 3;
               end else if (stl4 && m_run >= TH) begin
                  c = scan(m_owner, 1'b1);
                  if (c >= 0) begin m_target = c; m_phase = 2; end
               end
            end
         2: begin
               m_owner = m_target;
               m_run   = 0;
               m_phase = 1;
               if (m_sw < 65535) m_sw++;
            end
         default: if (!st4) begin m_fin = '0; m_phase = 0; m_sw = 0; end
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: advance model, sample #1 after the edge, check the 4-warp instance.
   task automatic tick();
      model_clock();
      @(posedge clk);
      #1;
      chk("sel4", 32'(sel4), 32'(m_owner));
      chk("sp4",  32'(sp4),  32'(m_phase == 2));
      chk("ad4",  32'(ad4),  32'(m_phase == 3));
      chk("dm4",  32'(dm4),  32'(m_fin));
`ifdef WARP_ARBITER_STATS_EN
      chk("sc4",  32'(sc4),  32'(m_sw));
`endif
   endtask

   initial begin
      int cyc;
      rst2 = 1; st2 = 0; stl2 = 0; dn2 = 0; act2 = 0; rdy2 = 0;
      rst4 = 1; st4 = 0; stl4 = 0; dn4 = 0; act4 = 0; rdy4 = 0;
      tick(); tick();
      chk("rst_sel2", 32'(sel2), 0);
      chk("rst_sp2",  32'(sp2),  0);
      chk("rst_ad2",  32'(ad2),  0);
      chk("rst_dm2",  32'(dm2),  0);
      rst2 = 0; rst4 = 0;

      // Launch: warp 0 owns the pipeline one cycle after start.
      act2 = 2'b11; st2 = 1;
      tick();
      chk("launch_sel2", 32'(sel2), 0);
      chk("launch_sp2",  32'(sp2),  0);
      chk("launch_ad2",  32'(ad2),  0);

      // Two stalled cycles hand off to warp 1.
      rdy2 = 2'b10; stl2 = 1;
      tick();
      chk("stall1_sp2", 32'(sp2), 0);
      tick();
      chk("stall2_sp2",  32'(sp2),  1);
      chk("stall2_sel2", 32'(sel2), 0);
      stl2 = 0;
      tick();
      chk("handoff_sel2", 32'(sel2), 1);
      chk("handoff_sp2",  32'(sp2),  0);

      // A single stalled cycle never switches.
      rdy2 = 2'b01; stl2 = 1;
      tick();
      stl2 = 0;
      tick(); tick();
      chk("short_sp2",  32'(sp2),  0);
      chk("short_sel2", 32'(sel2), 1);

      // Long stall with nobody ready stays put, then switches once warp 0 is ready.
      rdy2 = 2'b00; stl2 = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("noready_sp2",  32'(sp2),  0);
         chk("noready_sel2", 32'(sel2), 1);
      end
      rdy2 = 2'b01;
      tick();
      chk("ready_sp2", 32'(sp2), 1);
      stl2 = 0;
      tick();
      chk("ready_sel2", 32'(sel2), 0);

      // RET wins over a coincident stall; ready not required for the successor.
      rdy2 = 2'b00; dn2 = 1; stl2 = 1;
      tick();
      chk("ret0_dm2", 32'(dm2), 32'h1);
      chk("ret0_sp2", 32'(sp2), 1);
      dn2 = 0; stl2 = 0;
      tick();
      chk("ret0_sel2", 32'(sel2), 1);
      dn2 = 1;
      tick();
      chk("ret1_dm2", 32'(dm2), 32'h3);
      chk("ret1_ad2", 32'(ad2), 1);
      chk("ret1_sp2", 32'(sp2), 0);
      dn2 = 0;
      tick();
      chk("hold_ad2", 32'(ad2), 1);
      st2 = 0;
      tick();
      chk("clear_ad2", 32'(ad2), 0);
      chk("clear_dm2", 32'(dm2), 0);

      // Reset while in the handoff bubble.
      st2 = 1;
      tick();
      rdy2 = 2'b10; stl2 = 1;
      tick(); tick();
      chk("pre_rst_sp2", 32'(sp2), 1);
      rst2 = 1; stl2 = 0;
      tick();
      chk("mid_rst_sel2", 32'(sel2), 0);
      chk("mid_rst_sp2",  32'(sp2),  0);
      chk("mid_rst_dm2",  32'(dm2),  0);
      chk("mid_rst_ad2",  32'(ad2),  0);
      rst2 = 0; st2 = 0;
      tick();

      // 4 warps, active 1010: reach warp 3, then the scan wraps to warp 1.
      act4 = 4'b1010; st4 = 1;
      tick();
      chk("w4_first", 32'(sel4), 1);
      rdy4 = 4'b1000; stl4 = 1;
      tick(); tick();
      stl4 = 0;
      tick();
      chk("w4_to3", 32'(sel4), 3);
      rdy4 = 4'b1111; stl4 = 1;
      tick(); tick();
      stl4 = 0;
      tick();
      chk("w4_wrap", 32'(sel4), 1);
      dn4 = 1;
      for (int i = 0; i < 20 && m_phase != 3; i++) begin
         tick();
         dn4 = (m_phase == 1);
      end
      dn4 = 0;
      chk("w4_alldone", 32'(ad4), 1);

      // Randomized blocks against the model.
      for (int b = 0; b < 60; b++) begin
         st4 = 0; dn4 = 0; stl4 = 0; rst4 = 0;
         for (int i = 0; i < 5 && m_phase != 0; i++) tick();
         act4 = 4'($urandom);
         st4  = 1;
         cyc  = 0;
         while (m_phase != 3 && cyc < 400) begin
            rdy4 = 4'($urandom);
            stl4 = ($urandom_range(0, 2) != 0);
            dn4  = ($urandom_range(0, 5) == 0);
            rst4 = ($urandom_range(0, 299) == 0);
            tick();
            cyc++;
         end
         rst4 = 0; dn4 = 0; stl4 = 0;
         chk("blk_complete", 32'(ad4), 1);
      end
      st4 = 0;
      tick();
      chk("final_idle", 32'(ad4), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
